// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types, defaults and the oversample divider rule.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int OVS_DEFAULT = 16;

    // System clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        int d;
        d = clk_hz / (baud * ovs);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module : uart_baud_tick
// Brief  : Oversample tick generator with synchronous phase clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_tick = (r_div_cnt == c_LAST) && !i_clr;

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module : uart_rx_core
// Brief  : 8N1 UART receiver, 16x oversampled, valid strobe and framing error.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 96000,
    parameter int OVS    = OVS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] word,
    output logic       word_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            DIV       = calc_div(CLK_HZ, BAUD, OVS);
    localparam int            OW        = $clog2(OVS);
    localparam logic [OW-1:0] c_OS_LAST = OW'(OVS - 1);
    localparam logic [OW-1:0] c_OS_MID  = OW'(OVS / 2 - 1);

    logic          r_sync1;
    logic          r_rxs;
    logic          r_prev;
    state_t        r_state;
    logic [OW-1:0] r_os_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic [7:0]    r_word;
    logic          r_word_valid;
    logic          r_frame_err;
    logic          r_busy;
    logic          w_tick;
    logic          w_clr;

    // Divider is parked at zero while idle so sampling phase follows the start edge.
    assign w_clr = (r_state == IDLE);

    uart_baud_tick #(
        .DIV    (DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
            r_prev  <= r_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (r_prev && !r_rxs) begin
                        r_state   <= START;
                        r_os_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_OS_MID) begin
                            r_os_cnt <= '0;
                            if (r_rxs) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= DATA;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_OS_LAST) begin
                            r_os_cnt  <= '0;
                            r_shreg   <= {r_rxs, r_shreg[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_OS_LAST) begin
                            r_os_cnt <= '0;
                            if (r_rxs) begin
                                r_word       <= r_shreg;
                                r_word_valid <= 1'b1;
                                r_state      <= IDLE;
                                r_busy       <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Hold here so a line stuck low reports a single error.
                    if (r_rxs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module : tb_uart_rx_core
// Brief  : Scoreboard bench for uart_rx_core at 160 clocks per bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 10000;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] word;
    logic       word_valid;
    logic       frame_err;
    logic       busy;

    exp_t sb_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   t_start = 0;
    bit   lat_arm = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .word       (word),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame with start bit, data LSB first and chosen stop level; bit i ends at round((i+1)*num/den).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int num, input int den);
        logic [9:0] bits;
        int         dur;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = bits[i];
            if (i == 0) t_start = cyc;
            dur = ((i + 1) * num + den / 2) / den - (i * num + den / 2) / den;
            repeat (dur - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        sb_q.push_back(e);
    endtask

    initial begin
        bit seen_hi;
        bit fell;

        fork
            forever begin
                @(negedge clk);
                if (word_valid || frame_err) begin
                    check_val("valid_err_exclusive", {31'b0, word_valid & frame_err}, 32'd0);
                    if (sb_q.size() == 0) begin
                        check_val("spurious_strobe", {30'b0, word_valid, frame_err}, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check_val("strobe_kind", {31'b0, frame_err}, {31'b0, e.err});
                        if (!e.err) begin
                            check_val("word", {24'b0, word}, {24'b0, e.data});
                            check_val("busy_at_valid", {31'b0, busy}, 32'd0);
                            if (lat_arm) begin
                                check_val("latency", cyc - t_start, 32'd1523);
                                lat_arm = 1'b0;
                            end
                        end
                    end
                end
            end
        join_none

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_word", {24'b0, word}, 32'h00);
        check_val("rst_valid", {31'b0, word_valid}, 32'd0);
        check_val("rst_ferr", {31'b0, frame_err}, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        idle(20);

        // Single frame with latency measurement
        push(1'b0, 8'h55);
        lat_arm = 1'b1;
        fork
            send_frame(8'h55, 1'b1, 160, 1);
            begin
                repeat (800) @(negedge clk);
                check_val("busy_mid_frame", {31'b0, busy}, 32'd1);
            end
        join
        idle(50);
        check_val("drain_55", sb_q.size(), 32'd0);
        check_val("latency_seen", {31'b0, lat_arm}, 32'd0);

        // Back-to-back frames
        push(1'b0, 8'hA5);
        push(1'b0, 8'h3C);
        send_frame(8'hA5, 1'b1, 160, 1);
        send_frame(8'h3C, 1'b1, 160, 1);
        idle(50);
        check_val("drain_b2b", sb_q.size(), 32'd0);
        check_val("word_b2b", {24'b0, word}, 32'h3C);

        // Short low glitch: false start
        @(negedge clk);
        rxd     = 1'b0;
        seen_hi = 1'b0;
        fell    = 1'b0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (busy) seen_hi = 1'b1;
            else if (seen_hi) fell = 1'b1;
            if (i == 29) rxd = 1'b1;
            if (fell) break;
        end
        check_val("glitch_busy_rise", {31'b0, seen_hi}, 32'd1);
        check_val("glitch_busy_fall", {31'b0, fell}, 32'd1);
        idle(200);
        check_val("glitch_word", {24'b0, word}, 32'h3C);

        // Bad stop bit followed by a long break
        push(1'b1, 8'h00);
        send_frame(8'h81, 1'b0, 160, 1);
        repeat (2000) @(negedge clk);
        check_val("break_busy", {31'b0, busy}, 32'd1);
        check_val("break_word", {24'b0, word}, 32'h3C);
        check_val("drain_ferr", sb_q.size(), 32'd0);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        check_val("break_exit_busy", {31'b0, busy}, 32'd0);
        idle(200);

        // Reset mid-frame
        fork
            send_frame(8'hFF, 1'b1, 160, 1);
            begin
                repeat (640) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_val("midrst_word", {24'b0, word}, 32'h00);
                check_val("midrst_valid", {31'b0, word_valid}, 32'd0);
                check_val("midrst_ferr", {31'b0, frame_err}, 32'd0);
                check_val("midrst_busy", {31'b0, busy}, 32'd0);
            end
        join
        idle(100);
        push(1'b0, 8'h12);
        send_frame(8'h12, 1'b1, 160, 1);
        idle(50);
        check_val("word_after_rst", {24'b0, word}, 32'h12);

        // Line rate 2% fast: 160/1.02 clocks per bit
        push(1'b0, 8'h00);
        push(1'b0, 8'h0F);
        send_frame(8'h00, 1'b1, 16000, 102);
        send_frame(8'h0F, 1'b1, 16000, 102);
        idle(100);
        check_val("word_fast", {24'b0, word}, 32'h0F);

        for (int i = 0; i < 2000 && sb_q.size() > 0; i++) @(negedge clk);
        check_val("drain_final", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver for the serial link: deserialises the 8N1 stream on rxd into bytes.
- Receive-side counterpart to the transmit paths muxed onto txd by the top-level controller.
- Runs on the system clock with an internal 16x oversampling tick; no derived clocks.
- Delivers each byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 96000, line rate in bit/s.
- OVS, 16, oversampling ratio (even, >= 8).
- DIV, CLK_HZ/(BAUD*OVS) rounded down and forced to a minimum of 1, system clocks per oversample tick; derived, not overridden.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- rxd, input, 1, asynchronous serial line; idle high.
- word, output, 8, last correctly received byte.
- word_valid, output, 1, one-clk pulse when word updates.
- frame_err, output, 1, one-clk pulse on bad stop bit.
- busy, output, 1, high while a frame is in progress.

Behaviour:
- rxd synchroniser: 2 flops, both reset to 1; rxs is the second flop. prev flop holds last rxs (reset 1).
- Reset values: word=0x00, word_valid=0, frame_err=0, busy=0, state=IDLE, all counters 0. rst mid-frame aborts immediately; no strobe.
- Tick generator:
  - div_cnt counts 0..DIV-1.
  - tick=1 on the clk where div_cnt==DIV-1.
  - div_cnt is held at 0 in IDLE so sampling is phase-aligned to the detected start edge.
- os_cnt: 0..OVS-1, advances on tick; bit_cnt: 0..7.
- IDLE:
  - busy=0.
  - On prev==1 and rxs==0, go to START; clear div_cnt, os_cnt and bit_cnt.
- START:
  - At os_cnt==OVS/2-1 on tick (mid start bit), sample rxs.
  - rxs==1: false start (glitch), go to IDLE with no strobe.
  - rxs==0: clear os_cnt, go to DATA.
- DATA:
  - On each tick where os_cnt==OVS-1 (one bit period after the previous sample), shift rxs in LSB-first: shreg <= {rxs, shreg[7:1]}; clear os_cnt.
  - After the 8th sample (bit_cnt==7), go to STOP.
- STOP: on the next OVS-1 tick, sample rxs.
  - rxs==1: word <= shreg and word_valid=1 for exactly the following clk; go to IDLE.
  - rxs==0: frame_err=1 for exactly the following clk; word is unchanged; go to BREAK.
- BREAK: wait until rxs==1, then go to IDLE. A held-low line therefore gives one frame_err, not repeated errors.
- busy=1 in START, DATA, STOP and BREAK.
- Back-to-back frames: a start edge is accepted on the first clk back in IDLE; the stop sample is at mid-bit, leaving half a bit of slack.
- Latency: word_valid rises 1 clk after the mid-stop sample, about 9.5 bit times plus 3 clks after the start edge at the pin.
- word_valid and frame_err are never high together.
- There is no consumer handshake; a missed strobe simply loses the byte (word is still readable until the next good frame).

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - the OVS default;
  - a function calc_div(clk_hz, baud, ovs) implementing the DIV rule, for sharing with the TX side.
- One sub-module: uart_baud_tick (div_cnt plus tick, with a sync clear input). It is reusable by the transmitter.

Test Plan:
- Bench parameters: CLK_HZ=1600000, BAUD=10000, giving DIV=10 and 160 clks per bit.
- Frame 0x55, idle before and after -> word=0x55, word_valid high for 1 clk, frame_err=0, busy falls with valid.
- Back-to-back 0xA5 then 0x3C with zero idle between stop and next start -> two valid pulses, word=0xA5 then 0x3C, no frame_err.
- rxd low for 30 clks, then high -> no word_valid, no frame_err, busy returns to 0 within 90 clks of the edge, word unchanged.
- Frame 0x81 with stop bit driven 0, line then held low 2000 clks -> exactly one frame_err pulse, word keeps the prior 0x3C, busy stays 1 until rxd returns high.
- rst asserted for 1 clk mid-DATA of a 0xFF frame -> outputs go to reset values next clk; a following clean 0x12 frame is received correctly.
- 0x00 frame followed by an 0x0F frame at BAUD*1.02 line rate -> both received correctly, demonstrating ±2% tolerance.
